ov7670_sccb_sequencer: RTL and testbench
========================================

# ov7670_sccb_sequencer

Request-level controller between the camera HCI/configuration logic and the AXI-stream i2c master that drives SIO_C/SIO_D. It accepts one register write or read request at a time, expands it into SCCB-legal command/data beats (3-phase write; 2-phase write, STOP, then 2-phase read, with no repeated start), and returns a single-cycle response carrying read data and an error flag.

## Interface
- DEV_ADDR, 7'h21: 7-bit SCCB device address driven on s_axis_cmd_address.
- TIMEOUT_CYCLES, 1_000_000: cycles allowed per wait state before abort; only used with SCCB_TIMEOUT_EN.
- clk  in  1  system clock; all logic on posedge.
- reset_  in  1  asynchronous, active-low reset.
- req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both are high.
- req_write  in  1  1 = write, 0 = read.
- req_reg  in  8  register address.
- req_wdata  in  8  write value; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; 0 for writes and errors.
- rsp_error  out  1  timeout abort; valid with rsp_valid.
- busy  out  1  high in any state except IDLE.
- s_axis_cmd_address, s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write, s_axis_cmd_write_multiple, s_axis_cmd_stop, s_axis_cmd_valid  out  7,1,1,1,1,1,1  i2c master command channel.
- s_axis_cmd_ready  in  1.
- s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast  out  8,1,1  write-data channel; s_axis_data_tready in 1.
- m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast  in  8,1,1  read-data channel; m_axis_data_tready out 1.

## Operation
- States: IDLE, W_CMD, W_D0, W_D1, RW_CMD, RW_D0, RD_CMD, RD_WAIT, RESP.
- IDLE: req_ready=1. On handshake, latch req_write, req_reg and req_wdata; go to W_CMD if write, otherwise RW_CMD.
- W_CMD: cmd start=1, write_multiple=1, stop=1. On cmd handshake go to W_D0.
- W_D0: tdata=reg, tlast=0. On handshake go to W_D1.
- W_D1: tdata=wdata, tlast=1. On handshake go to RESP.
- RW_CMD: same command as W_CMD. On handshake go to RW_D0.
- RW_D0: tdata=reg, tlast=1. On handshake go to RD_CMD.
- RD_CMD: cmd start=1, read=1, stop=1. On handshake go to RD_WAIT.
- RD_WAIT: m_axis_data_tready=1. On tvalid, capture tdata into rsp_rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Command flags not listed for a state are 0. s_axis_cmd_address is DEV_ADDR in every state.
- valid signals stay high and payloads stay stable until ready. A valid signal never drops without a handshake, except on timeout abort.
- req_valid arriving while busy is not accepted (req_ready=0). There is no queueing.
- m_axis_data_tready=0 outside RD_WAIT. Stray read bytes stall in the i2c master.
- m_axis_data_tlast is ignored.

## Timing
- Reset values: req_ready=1; busy, rsp_valid, rsp_error, all valid outputs, all cmd flags, tlast and m_axis_data_tready are 0; rsp_rdata=0; state=IDLE.
- All outputs are registered or decoded from registered state, with no combinational input-to-output path.
- Request accepted in cycle N: s_axis_cmd_valid is high in N+1.
- Zero-wait downstream (ready always 1): write reaches rsp_valid at N+4; read reaches rsp_valid at N+4+k, where k = cycles until m_axis_data_tvalid in RD_WAIT.
- Next request can be accepted in the cycle after the rsp_valid pulse.
- Reset asserted mid-transaction returns to reset values immediately. The partial i2c transfer is the i2c master's responsibility.

## Configuration
- SCCB_TIMEOUT_EN defined:
  - A 20-bit wait counter clears on every state entry and increments while a handshake is pending.
  - When it reaches TIMEOUT_CYCLES-1 in any wait state, all valid/ready outputs drop and the block enters RESP with rsp_error=1 and rsp_rdata=0.
- Undefined: no counter. rsp_error is tied to 0, and the block waits indefinitely.

## Test plan
- Write 0x12←0x80, ready always 1: one cmd beat (start, write_multiple, stop; addr 0x21), data 0x12 (tlast=0) then 0x80 (tlast=1), rsp_valid at N+4 with rsp_error=0.
- Read 0x0A, slave returns 0x76 after 10 cycles: cmd write_multiple, data 0x0A with tlast=1, cmd read, then rsp_rdata=0x76 and one-cycle rsp_valid.
- Backpressure: s_axis_data_tready toggles randomly → no byte lost, duplicated or changed while valid; order is reg then value.
- req_valid held high during an in-flight write → req_ready=0 until after rsp_valid; the second request starts the cycle after IDLE is re-entered.
- SCCB_TIMEOUT_EN with TIMEOUT_CYCLES=16, s_axis_cmd_ready stuck 0 → rsp_valid at cycle 16 after W_CMD entry, rsp_error=1, s_axis_cmd_valid=0 thereafter.
- reset_ pulsed low in RD_WAIT → every output returns to its reset value asynchronously, and a fresh request then completes normally.

Source files
------------

// File: rtl/ov7670_sccb_sequencer.sv
// Expands single OV7670 register read/write requests into SCCB command/data beats for an AXI-stream i2c master.
// Optional per-wait-state timeout abort is compiled in when SCCB_TIMEOUT_EN is defined.
module ov7670_sccb_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h21,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic       busy,
    output logic [6:0] s_axis_cmd_address,
    output logic       s_axis_cmd_start,
    output logic       s_axis_cmd_read,
    output logic       s_axis_cmd_write,
    output logic       s_axis_cmd_write_multiple,
    output logic       s_axis_cmd_stop,
    output logic       s_axis_cmd_valid,
    input  logic       s_axis_cmd_ready,
    output logic [7:0] s_axis_data_tdata,
    output logic       s_axis_data_tvalid,
    output logic       s_axis_data_tlast,
    input  logic       s_axis_data_tready,
    input  logic [7:0] m_axis_data_tdata,
    input  logic       m_axis_data_tvalid,
    input  logic       m_axis_data_tlast,
    output logic       m_axis_data_tready
);

    typedef enum logic [3:0] {
        IDLE, W_CMD, W_D0, W_D1, RW_CMD, RW_D0, RD_CMD, RD_WAIT, RESP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       timeout_hit;
    logic       abort;
    logic       unused_bits;

    assign s_axis_cmd_address = DEV_ADDR;
    assign s_axis_cmd_write   = 1'b0;
    assign unused_bits        = ^{m_axis_data_tlast, TIMEOUT_CYCLES};

`ifdef SCCB_TIMEOUT_EN
    logic [19:0] wait_cnt;

    assign timeout_hit = (state != IDLE) && (state != RESP) &&
                         (wait_cnt == 20'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in the current state; restarts on every transition.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (state != IDLE && state != RESP) begin
            wait_cnt <= wait_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rsp_error <= 1'b0;
        end else begin
            rsp_error <= abort;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_error   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE:    if (req_valid) state_next = req_write ? W_CMD : RW_CMD;
            W_CMD:   if (s_axis_cmd_ready) state_next = W_D0;
            W_D0:    if (s_axis_data_tready) state_next = W_D1;
            W_D1:    if (s_axis_data_tready) state_next = RESP;
            RW_CMD:  if (s_axis_cmd_ready) state_next = RW_D0;
            RW_D0:   if (s_axis_data_tready) state_next = RD_CMD;
            RD_CMD:  if (s_axis_cmd_ready) state_next = RD_WAIT;
            RD_WAIT: if (m_axis_data_tvalid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A handshake in the final allowed cycle wins over the abort.
        if (timeout_hit && state_next == state) begin
            state_next = RESP;
            abort      = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state                     <= IDLE;
            reg_addr                  <= 8'h00;
            wr_data                   <= 8'h00;
            req_ready                 <= 1'b1;
            busy                      <= 1'b0;
            rsp_valid                 <= 1'b0;
            rsp_rdata                 <= 8'h00;
            s_axis_cmd_valid          <= 1'b0;
            s_axis_cmd_start          <= 1'b0;
            s_axis_cmd_read           <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b0;
            s_axis_cmd_stop           <= 1'b0;
            s_axis_data_tvalid        <= 1'b0;
            s_axis_data_tdata         <= 8'h00;
            s_axis_data_tlast         <= 1'b0;
            m_axis_data_tready        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                reg_addr <= req_reg;
                wr_data  <= req_wdata;
            end
            req_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
            rsp_rdata <= (state == RD_WAIT && state_next == RESP && !abort) ? m_axis_data_tdata : 8'h00;

            s_axis_cmd_valid          <= (state_next == W_CMD) || (state_next == RW_CMD) || (state_next == RD_CMD);
            s_axis_cmd_start          <= (state_next == W_CMD) || (state_next == RW_CMD) || (state_next == RD_CMD);
            s_axis_cmd_stop           <= (state_next == W_CMD) || (state_next == RW_CMD) || (state_next == RD_CMD);
            s_axis_cmd_write_multiple <= (state_next == W_CMD) || (state_next == RW_CMD);
            s_axis_cmd_read           <= (state_next == RD_CMD);

            // Data states are only reached after the request has been latched.
            s_axis_data_tvalid <= (state_next == W_D0) || (state_next == W_D1) || (state_next == RW_D0);
            s_axis_data_tdata  <= (state_next == W_D1) ? wr_data : reg_addr;
            s_axis_data_tlast  <= (state_next == W_D1) || (state_next == RW_D0);
            m_axis_data_tready <= (state_next == RD_WAIT);
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_sequencer.sv
// Directed self-checking bench for ov7670_sccb_sequencer; timeout steps compile only with SCCB_TIMEOUT_EN.
module tb_ov7670_sccb_sequencer;

    logic       clk = 1'b0;
    logic       reset_;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_reg, req_wdata;
    logic       rsp_valid, rsp_error, busy;
    logic [7:0] rsp_rdata;
    logic [6:0] s_axis_cmd_address;
    logic       s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write;
    logic       s_axis_cmd_write_multiple, s_axis_cmd_stop, s_axis_cmd_valid;
    logic       s_axis_cmd_ready = 1'b1;
    logic [7:0] s_axis_data_tdata;
    logic       s_axis_data_tvalid, s_axis_data_tlast;
    logic       s_axis_data_tready = 1'b1;
    logic [7:0] m_axis_data_tdata;
    logic       m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready;

    int checks   = 0;
    int failures = 0;

    logic        bp_en     = 1'b0;
    logic        cmd_stuck = 1'b0;
    logic [15:0] bp_pat    = 16'b1001_1100_1010_0110;
    int          bp_idx    = 0;

    logic [4:0] cmd_flags;
    logic [8:0] data_q[$];
    logic [4:0] cmd_q[$];
    logic       data_stall = 1'b0, cmd_stall = 1'b0;
    logic [8:0] data_saved;
    logic [4:0] cmd_saved;

    assign cmd_flags = {s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write,
                        s_axis_cmd_write_multiple, s_axis_cmd_stop};

    always #5 clk = ~clk;

    ov7670_sccb_sequencer #(.DEV_ADDR(7'h21), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_(reset_),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
        .s_axis_cmd_address(s_axis_cmd_address), .s_axis_cmd_start(s_axis_cmd_start),
        .s_axis_cmd_read(s_axis_cmd_read), .s_axis_cmd_write(s_axis_cmd_write),
        .s_axis_cmd_write_multiple(s_axis_cmd_write_multiple), .s_axis_cmd_stop(s_axis_cmd_stop),
        .s_axis_cmd_valid(s_axis_cmd_valid), .s_axis_cmd_ready(s_axis_cmd_ready),
        .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
        .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
        .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tlast(m_axis_data_tlast), .m_axis_data_tready(m_axis_data_tready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {req_ready, busy, rsp_valid, rsp_error, s_axis_cmd_valid, cmd_flags,
                               s_axis_data_tvalid, s_axis_data_tlast, m_axis_data_tready}, 32'h1000);
        check({tag, "_rdata"}, rsp_rdata, 8'h00);
        check({tag, "_addr"}, s_axis_cmd_address, 7'h21);
    endtask

    task automatic wait_rsp(input string tag, input int limit);
        int waited = 0;
        while (!rsp_valid && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    endtask

    task automatic issue(input logic wr, input logic [7:0] ra, input logic [7:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_reg   = ra;
        req_wdata = wd;
    endtask

    // Ready pattern generator; data and command channels use offset phases of one bit pattern.
    always @(negedge clk) begin
        s_axis_data_tready = bp_en ? bp_pat[bp_idx % 16] : 1'b1;
        s_axis_cmd_ready   = cmd_stuck ? 1'b0 : (bp_en ? bp_pat[(bp_idx + 5) % 16] : 1'b1);
        bp_idx = bp_idx + 1;
    end

    // Beat capture plus hold-while-stalled checks on both outbound channels.
    always @(posedge clk) begin
        if (!reset_) begin
            data_stall = 1'b0;
            cmd_stall  = 1'b0;
        end else begin
            if (data_stall && !cmd_stuck)
                check("data_hold", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {1'b1, data_saved});
            if (cmd_stall && !cmd_stuck)
                check("cmd_hold", {s_axis_cmd_valid, cmd_flags}, {1'b1, cmd_saved});
            if (s_axis_data_tvalid && s_axis_data_tready) data_q.push_back({s_axis_data_tlast, s_axis_data_tdata});
            if (s_axis_cmd_valid && s_axis_cmd_ready) cmd_q.push_back(cmd_flags);
            data_stall = s_axis_data_tvalid && !s_axis_data_tready;
            data_saved = {s_axis_data_tlast, s_axis_data_tdata};
            cmd_stall  = s_axis_cmd_valid && !s_axis_cmd_ready;
            cmd_saved  = cmd_flags;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_reg = 8'h00; req_wdata = 8'h00;
        m_axis_data_tvalid = 1'b0; m_axis_data_tdata = 8'h00; m_axis_data_tlast = 1'b0;
        step(3);
        check_reset_outputs("reset");
        reset_ = 1'b1;
        step(2);
        check_reset_outputs("idle");

        // Write 0x12 <- 0x80, zero-wait downstream.
        data_q.delete(); cmd_q.delete();
        issue(1'b1, 8'h12, 8'h80);
        step(1); req_valid = 1'b0;
        check("w_cmd_valid", s_axis_cmd_valid, 1'b1);
        check("w_cmd_flags", cmd_flags, 5'b10011);
        check("w_cmd_addr", s_axis_cmd_address, 7'h21);
        check("w_busy", {req_ready, busy}, 2'b01);
        step(1);
        check("w_d0", {s_axis_cmd_valid, s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {3'b010, 8'h12});
        step(1);
        check("w_d1", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b11, 8'h80});
        step(1);
        check("w_rsp", {rsp_valid, rsp_error, s_axis_data_tvalid, rsp_rdata}, {3'b100, 8'h00});
        step(1);
        check("w_after", {rsp_valid, req_ready, busy}, 3'b010);

        // Read 0x0A, slave answers 0x76 about ten cycles into the wait.
        data_q.delete(); cmd_q.delete();
        issue(1'b0, 8'h0A, 8'h00);
        step(1); req_valid = 1'b0;
        check("r_cmd1", {s_axis_cmd_valid, cmd_flags}, 6'b110011);
        step(1);
        check("r_d0", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b11, 8'h0A});
        step(1);
        check("r_cmd2", {s_axis_cmd_valid, cmd_flags}, 6'b111001);
        step(1);
        check("r_wait", {m_axis_data_tready, busy, s_axis_cmd_valid}, 3'b110);
        step(9);
        check("r_wait_hold", {rsp_valid, m_axis_data_tready}, 2'b01);
        m_axis_data_tvalid = 1'b1; m_axis_data_tdata = 8'h76; m_axis_data_tlast = 1'b1;
        step(1);
        m_axis_data_tvalid = 1'b0;
        check("r_rsp", {rsp_valid, rsp_error, m_axis_data_tready}, 3'b100);
        check("r_rdata", rsp_rdata, 8'h76);
        step(1);
        check("r_pulse", rsp_valid, 1'b0);
        check("r_cmd_beats", {cmd_q.size(), cmd_q[0], cmd_q[1]}, {32'd2, 5'b10011, 5'b11001});
        check("r_data_beats", {data_q.size(), data_q[0]}, {32'd1, 9'h10A});

        // Write and read with toggling ready on both outbound channels.
        data_q.delete(); cmd_q.delete();
        bp_en = 1'b1;
        issue(1'b1, 8'h34, 8'h56);
        step(1); req_valid = 1'b0;
        wait_rsp("bpw", 100);
        check("bpw_err", rsp_error, 1'b0);
        step(1);
        check("bpw_beats", {data_q.size(), data_q[0], data_q[1]}, {32'd2, 9'h034, 9'h156});
        check("bpw_cmds", {cmd_q.size(), cmd_q[0]}, {32'd1, 5'b10011});
        data_q.delete(); cmd_q.delete();
        m_axis_data_tvalid = 1'b1; m_axis_data_tdata = 8'h5A;
        issue(1'b0, 8'h0B, 8'h00);
        step(1); req_valid = 1'b0;
        wait_rsp("bpr", 100);
        check("bpr_rdata", rsp_rdata, 8'h5A);
        m_axis_data_tvalid = 1'b0;
        step(1);
        check("bpr_beats", {data_q.size(), data_q[0], cmd_q.size(), cmd_q[0], cmd_q[1]},
              {32'd1, 9'h10B, 32'd2, 5'b10011, 5'b11001});
        bp_en = 1'b0;
        step(2);

        // Second request held on req_valid while the first write is in flight.
        data_q.delete(); cmd_q.delete();
        issue(1'b1, 8'h11, 8'h22);
        step(1);
        req_reg = 8'h3A; req_wdata = 8'h04;
        check("hold_n1", req_ready, 1'b0);
        step(2);
        check("hold_n3", req_ready, 1'b0);
        step(1);
        check("hold_n4", {rsp_valid, req_ready}, 2'b10);
        step(1);
        check("hold_n5", {rsp_valid, req_ready, s_axis_cmd_valid}, 3'b010);
        step(1);
        req_valid = 1'b0;
        check("hold_n6", {s_axis_cmd_valid, req_ready, busy}, 3'b101);
        wait_rsp("hold2", 20);
        step(1);
        check("hold_beats", {data_q.size(), data_q[0], data_q[1], data_q[2], data_q[3]},
              {32'd4, 9'h011, 9'h122, 9'h03A, 9'h104});

        // Asynchronous reset while waiting for read data, then a fresh read.
        issue(1'b0, 8'h1C, 8'h00);
        step(1); req_valid = 1'b0;
        step(3);
        check("rst_in_wait", m_axis_data_tready, 1'b1);
        #2 reset_ = 1'b0;
        #1 check_reset_outputs("async_reset");
        step(1);
        reset_ = 1'b1;
        step(1);
        m_axis_data_tvalid = 1'b1; m_axis_data_tdata = 8'h7F;
        issue(1'b0, 8'h1D, 8'h00);
        step(1); req_valid = 1'b0;
        step(3);
        check("fresh_n4", {rsp_valid, m_axis_data_tready}, 2'b01);
        step(1);
        check("fresh_n5", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 8'h7F});
        m_axis_data_tvalid = 1'b0;
        step(1);

`ifdef SCCB_TIMEOUT_EN
        // Command channel never ready: abort 16 cycles after W_CMD entry.
        cmd_stuck = 1'b1;
        step(2);
        issue(1'b1, 8'h40, 8'h01);
        step(1); req_valid = 1'b0;
        check("to_entry", s_axis_cmd_valid, 1'b1);
        step(15);
        check("to_n16", {rsp_valid, s_axis_cmd_valid}, 2'b01);
        step(1);
        check("to_rsp", {rsp_valid, rsp_error, s_axis_cmd_valid, rsp_rdata}, {3'b110, 8'h00});
        step(1);
        check("to_after", {rsp_valid, s_axis_cmd_valid, req_ready}, 3'b001);
        cmd_stuck = 1'b0;
        step(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
